rtlup_master: RTL and testbench
===============================

RTLUP_MASTER -- requirements
Module: rtlup_master

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the microprocessor data width.
REQ-002 The block SHALL have parameter AWIDTH, default 8, giving the microprocessor address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum wait cycles for uprdy; 0 means wait forever.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 req_vld  input  1  request valid.
REQ-007 req_rdy  output  1  request accepted when req_vld & req_rdy at an edge.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AWIDTH  target address.
REQ-010 req_data  input  WIDTH  write data.
REQ-011 rsp_vld  output  1  one-cycle response pulse.
REQ-012 rsp_data  output  WIDTH  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  timeout flag, valid with rsp_vld.
REQ-014 upen  output  1  bus enable to responder.
REQ-015 upws  output  1  write strobe.
REQ-016 uprs  output  1  read strobe.
REQ-017 upa  output  AWIDTH  bus address.
REQ-018 updi  output  WIDTH  bus write data, toward responder.
REQ-019 updo  input  WIDTH  bus read data, from responder.
REQ-020 uprdy  input  1  responder ready, one cycle after strobe for zero-wait responders.

Function
REQ-021 All outputs SHALL be registered; FSM states SHALL be IDLE, STRB, WAIT, RESP.
REQ-022 req_rdy SHALL be 1 only in IDLE.
REQ-023 On acceptance the block SHALL latch req_wr/addr/data, enter STRB, and drive upen=1, upa, updi, and upws (write) or uprs (read) from the next cycle.
REQ-024 STRB SHALL last exactly one cycle; in WAIT upen, upa and updi SHALL hold, and upws=uprs=0.
REQ-025 In WAIT, uprdy=1 SHALL capture updo (read) or 0 (write) into rsp_data, set rsp_err=0, drop upen, and enter RESP.
REQ-026 With a zero-wait responder, rsp_vld SHALL assert on the 2nd rising edge after the accepting edge.
REQ-027 The WAIT counter SHALL clear on entry and increment each WAIT cycle with uprdy=0; on reaching TIMEOUT the block SHALL enter RESP with rsp_err=1, rsp_data=0, upen=0.
REQ-028 uprdy=1 in the same cycle the counter would expire SHALL count as success (rsp_err=0).
REQ-029 uprdy in IDLE, STRB or RESP SHALL be ignored.
REQ-030 RESP SHALL last one cycle with rsp_vld=1, then return to IDLE; back-to-back requests therefore have at least 4 cycles between acceptances.
REQ-031 rsp_data and rsp_err SHALL hold their values until the next response.
REQ-032 At most one transaction SHALL be outstanding; upws and uprs SHALL never both be 1.

Reset
REQ-033 rst=0 SHALL force state IDLE, counter 0, and all outputs 0, except req_rdy, which SHALL be 1 after reset releases.
REQ-034 Reset mid-transaction SHALL abort the transaction without a response pulse; bus strobes SHALL drop immediately.

Structure
REQ-035 The shared package SHALL hold the state encoding (2-bit), the default WIDTH/AWIDTH/TIMEOUT constants and the counter width, clog2(TIMEOUT+1).
REQ-036 The timeout counter SHALL be one sub-module, uptimeout (clear, enable, expired output); everything else stays in rtlup_master.

Verification
REQ-037 Write addr 0x12 data 0xA5 against a zero-wait config-register responder -> one upws pulse, rsp_vld 2 edges after accept, rsp_err=0, register reads 0xA5.
REQ-038 Read back addr 0x12 -> one uprs pulse, rsp_data=0xA5, rsp_err=0.
REQ-039 Responder never asserts uprdy, TIMEOUT=16 -> rsp_vld after 16 WAIT cycles, rsp_err=1, rsp_data=0, upen low afterward.
REQ-040 uprdy asserted exactly on the expiry cycle with updo=0x3C -> rsp_err=0, rsp_data=0x3C.
REQ-041 req_vld held high for 3 requests; spurious uprdy in IDLE -> exactly 3 responses in order, spurious pulse ignored, req_rdy low between accept and RESP.
REQ-042 Reset asserted during WAIT -> upen, upws, uprs and rsp_vld all 0 immediately; no response; req_rdy=1 after release.

Source files
------------

// File: rtl/rtlup_master_pkg.sv
// Shared definitions for the rtlup_master bus master.
//   state_t     : 2-bit FSM encoding (IDLE, STRB, WAIT, RESP)
//   DEF_*       : default data width, address width and uprdy timeout
//   cnt_width() : width of the WAIT-cycle counter, clog2(timeout+1), minimum 1
package rtlup_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_AWIDTH  = 8;
    localparam int DEF_TIMEOUT = 16;

    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/rtlup_master_uptimeout.sv
// WAIT-cycle counter for rtlup_master.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : return the count to zero (held while not waiting)
//   enable   : count one WAIT cycle without uprdy
//   expired  : this enabled cycle is the TIMEOUT-th one; never asserts when TIMEOUT=0
module uptimeout
    import rtlup_master_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = cnt_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry is flagged during the cycle whose increment would reach TIMEOUT,
    // so the master can still give a same-cycle uprdy priority over it.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/rtlup_master.sv
// Request/response to microprocessor-bus master. One transaction at a time:
// accept a request, pulse upws/uprs for one cycle, wait for uprdy (bounded by
// TIMEOUT), then emit a one-cycle rsp_vld with rsp_data/rsp_err.
//   clk, rst                       : clock, asynchronous active-low reset
//   req_vld/req_rdy/req_wr/
//   req_addr/req_data              : request handshake and payload
//   rsp_vld/rsp_data/rsp_err       : response pulse, read data, timeout flag
//   upen/upws/uprs/upa/updi        : bus enable, strobes, address, write data
//   updo/uprdy                     : bus read data and responder ready
module rtlup_master
    import rtlup_master_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int AWIDTH  = DEF_AWIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_wr,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    output logic              rsp_vld,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              upen,
    output logic              upws,
    output logic              uprs,
    output logic [AWIDTH-1:0] upa,
    output logic [WIDTH-1:0]  updi,
    input  logic [WIDTH-1:0]  updo,
    input  logic              uprdy
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t            state, state_next;
    logic              wr, wr_next;
    logic              req_rdy_next, upen_next, upws_next, uprs_next;
    logic              rsp_vld_next, rsp_err_next;
    logic [AWIDTH-1:0] upa_next;
    logic [WIDTH-1:0]  updi_next, rsp_data_next;
    logic              cnt_clear, cnt_enable, cnt_expired;

    assign cnt_clear  = (state != WAIT);
    assign cnt_enable = (state == WAIT) && !uprdy;

    uptimeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next    = state;
        wr_next       = wr;
        upen_next     = upen;
        upws_next     = 1'b0;
        uprs_next     = 1'b0;
        upa_next      = upa;
        updi_next     = updi;
        rsp_vld_next  = 1'b0;
        rsp_data_next = rsp_data;
        rsp_err_next  = rsp_err;
        case (state)
            IDLE: begin
                // req_rdy is only ever high in IDLE
                if (req_vld && req_rdy) begin
                    state_next = STRB;
                    wr_next    = req_wr;
                    upen_next  = 1'b1;
                    upws_next  = req_wr;
                    uprs_next  = !req_wr;
                    upa_next   = req_addr;
                    updi_next  = req_data;
                end
            end
            STRB: begin
                state_next = WAIT;
            end
            WAIT: begin
                // uprdy wins over a same-cycle expiry
                if (uprdy) begin
                    state_next    = RESP;
                    upen_next     = 1'b0;
                    rsp_vld_next  = 1'b1;
                    rsp_data_next = wr ? '0 : updo;
                    rsp_err_next  = 1'b0;
                end else if (cnt_expired) begin
                    state_next    = RESP;
                    upen_next     = 1'b0;
                    rsp_vld_next  = 1'b1;
                    rsp_data_next = '0;
                    rsp_err_next  = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        req_rdy_next = (state_next == IDLE);
    end

    // req_rdy resets low and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr       <= 1'b0;
            req_rdy  <= 1'b0;
            upen     <= 1'b0;
            upws     <= 1'b0;
            uprs     <= 1'b0;
            upa      <= '0;
            updi     <= '0;
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wr       <= wr_next;
            req_rdy  <= req_rdy_next;
            upen     <= upen_next;
            upws     <= upws_next;
            uprs     <= uprs_next;
            upa      <= upa_next;
            updi     <= updi_next;
            rsp_vld  <= rsp_vld_next;
            rsp_data <= rsp_data_next;
            rsp_err  <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_rtlup_master.sv
// Self-checking bench for rtlup_master (WIDTH=AWIDTH=8, TIMEOUT=16) with a
// configurable register-file responder on the bus side.
module tb_rtlup_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic       rsp_vld;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       upen, upws, uprs;
    logic [7:0] upa, updi;
    logic [7:0] updo = 8'h00;
    logic       uprdy = 1'b0;

    rtlup_master #(
        .WIDTH   (8),
        .AWIDTH  (8),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_data (req_data),
        .rsp_vld  (rsp_vld),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .upen     (upen),
        .upws     (upws),
        .uprs     (uprs),
        .upa      (upa),
        .updi     (updi),
        .updo     (updo),
        .uprdy    (uprdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Scoreboard of expected responses
    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Responder: register file; uprdy in the rdy_delay-th cycle after the strobe
    logic [7:0] mem [256];
    int   rdy_delay = 1;
    logic silent = 1'b0;
    logic spur = 1'b0;
    logic pend = 1'b0;
    logic pwr = 1'b0;
    logic [7:0] paddr = 8'h00;
    int   pcnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
        forever begin
            @(posedge clk);
            #2;
            uprdy = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (spur) begin
                uprdy = 1'b1;
                updo  = 8'h99;
                spur  = 1'b0;
            end else if (pend) begin
                pcnt++;
                if (pcnt == rdy_delay) begin
                    uprdy = 1'b1;
                    updo  = pwr ? 8'h00 : mem[paddr];
                    pend  = 1'b0;
                end
            end
            if (rst && !silent && (upws || uprs)) begin
                pend  = 1'b1;
                pcnt  = 0;
                pwr   = upws;
                paddr = upa;
                if (upws) mem[upa] = updi;
            end
        end
    end

    // Monitor: strobe counts, exclusivity, response checking
    int   nws = 0, nrs = 0, nrsp = 0;
    logic both_seen = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (upws && uprs) both_seen = 1'b1;
        if (upws) nws++;
        if (uprs) nrs++;
        if (rsp_vld) begin
            nrsp++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_rsp: rsp_vld=1 data=%0h err=%0b, required no response (cycle %0d)",
                         rsp_data, rsp_err, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive one request; returns at #1 after the accepting edge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee, input int lat,
                         input logic keep, output int acc);
        int   n = 0;
        logic rdy_b;
        logic got = 1'b0;
        exp_t e;
        req_vld  = 1'b1;
        req_wr   = w;
        req_addr = a;
        req_data = d;
        while (!got && n < 100) begin
            rdy_b = req_rdy;
            @(posedge clk);
            #1;
            got = rdy_b;
            n++;
        end
        acc = cyc;
        if (!got) begin
            total_cnt++;
            $display("FAIL accept_timeout: req_rdy stayed 0, required 1 within 100 cycles");
        end else begin
            e.data = ed;
            e.err  = ee;
            e.cyc  = cyc + lat;
            sb.push_back(e);
            chk("rdy_low_after_accept", 32'(req_rdy), 32'd0);
        end
        if (!keep) req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         dly;
        logic       sil;
        logic [7:0] exp_data;
        logic       exp_err;
        int         lat;
    } vec_t;
    vec_t vt [13];

    initial begin
        int acc0, acc1, acc2, ws0, rs0, r0;

        vt[0]  = '{1'b1, 8'h12, 8'hA5, 1,  1'b0, 8'h00, 1'b0, 2};
        vt[1]  = '{1'b0, 8'h12, 8'h00, 1,  1'b0, 8'hA5, 1'b0, 2};
        vt[2]  = '{1'b1, 8'h34, 8'h5A, 1,  1'b0, 8'h00, 1'b0, 2};
        vt[3]  = '{1'b0, 8'h34, 8'h00, 1,  1'b0, 8'h5A, 1'b0, 2};
        vt[4]  = '{1'b0, 8'h55, 8'h00, 1,  1'b0, 8'hAA, 1'b0, 2};
        vt[5]  = '{1'b1, 8'h12, 8'hFF, 3,  1'b0, 8'h00, 1'b0, 4};
        vt[6]  = '{1'b0, 8'h12, 8'h00, 5,  1'b0, 8'hFF, 1'b0, 6};
        vt[7]  = '{1'b1, 8'h40, 8'h3C, 1,  1'b0, 8'h00, 1'b0, 2};
        vt[8]  = '{1'b0, 8'h40, 8'h00, 16, 1'b0, 8'h3C, 1'b0, 17};
        vt[9]  = '{1'b0, 8'h40, 8'h00, 17, 1'b0, 8'h00, 1'b1, 17};
        vt[10] = '{1'b0, 8'h40, 8'h00, 1,  1'b1, 8'h00, 1'b1, 17};
        vt[11] = '{1'b1, 8'h41, 8'h77, 1,  1'b1, 8'h00, 1'b1, 17};
        vt[12] = '{1'b0, 8'h41, 8'h00, 1,  1'b0, 8'hBE, 1'b0, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upen", 32'(upen), 32'd0);
        chk("rst_upws", 32'(upws), 32'd0);
        chk("rst_uprs", 32'(uprs), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_upa", 32'(upa), 32'd0);
        chk("rst_updi", 32'(updi), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_reset", 32'(req_rdy), 32'd1);

        // Table-driven transactions
        for (int i = 0; i < 13; i++) begin
            rdy_delay = vt[i].dly;
            silent    = vt[i].sil;
            ws0 = nws;
            rs0 = nrs;
            issue(vt[i].wr, vt[i].addr, vt[i].data, vt[i].exp_data, vt[i].exp_err,
                  vt[i].lat, 1'b0, acc0);
            wait_idle();
            chk("upws_pulses", 32'(nws - ws0), vt[i].wr ? 32'd1 : 32'd0);
            chk("uprs_pulses", 32'(nrs - rs0), vt[i].wr ? 32'd0 : 32'd1);
            if (i == 0) chk("reg_12_written", 32'(mem[8'h12]), 32'hA5);
            if (vt[i].exp_err) chk("upen_after_timeout", 32'(upen), 32'd0);
        end
        silent    = 1'b0;
        rdy_delay = 1;

        // Spurious uprdy in IDLE
        r0 = nrsp;
        spur = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("spurious_ignored", 32'(nrsp - r0), 32'd0);
        chk("rdy_after_spurious", 32'(req_rdy), 32'd1);

        // Back-to-back with req_vld held high
        r0 = nrsp;
        issue(1'b1, 8'h70, 8'h11, 8'h00, 1'b0, 2, 1'b1, acc0);
        issue(1'b0, 8'h70, 8'h00, 8'h11, 1'b0, 2, 1'b1, acc1);
        issue(1'b0, 8'h34, 8'h00, 8'h5A, 1'b0, 2, 1'b0, acc2);
        wait_idle();
        chk("stream_count", 32'(nrsp - r0), 32'd3);
        chk("stream_gap_1", 32'(acc1 - acc0), 32'd4);
        chk("stream_gap_2", 32'(acc2 - acc1), 32'd4);

        // Reset during WAIT
        silent = 1'b1;
        issue(1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 17, 1'b0, acc0);
        repeat (3) @(posedge clk);
        #1;
        chk("wait_upen", 32'(upen), 32'd1);
        chk("wait_upws", 32'(upws), 32'd0);
        chk("wait_uprs", 32'(uprs), 32'd0);
        chk("wait_upa", 32'(upa), 32'h20);
        r0 = nrsp;
        rst = 1'b0;
        #1;
        sb.delete();
        chk("abort_upen", 32'(upen), 32'd0);
        chk("abort_upws", 32'(upws), 32'd0);
        chk("abort_uprs", 32'(uprs), 32'd0);
        chk("abort_rsp_vld", 32'(rsp_vld), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        silent = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("no_rsp_after_abort", 32'(nrsp - r0), 32'd0);
        chk("rdy_after_abort", 32'(req_rdy), 32'd1);

        // Normal operation resumes
        issue(1'b0, 8'h34, 8'h00, 8'h5A, 1'b0, 2, 1'b0, acc0);
        wait_idle();

        chk("strobe_exclusive", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
